// File: rtl/csr_bank_if.sv
// CSR bank bus: read ports, software write port, hardware status port, instret strobe.
// Latency: none added; this is a bundle of wires.
// Backpressure: none. Every strobe is accepted in the cycle it is presented.
interface csr_bank_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] iw_read_addr;
    logic [NUM_RD*DATA_W-1:0] ow_read_data;
    logic                     iw_write_enable;
    logic [ADDR_W-1:0]        iw_write_addr;
    logic [DATA_W-1:0]        iw_write_data;
    logic [1:0]               iw_write_mode;
    logic                     iw_hw_we;
    logic [ADDR_W-1:0]        iw_hw_addr;
    logic [DATA_W-1:0]        iw_hw_data;
    logic                     iw_instret;
    logic                     ow_write_err;

    // Pipeline side: issues reads and writes, observes data and errors.
    modport master (
        output iw_read_addr, iw_write_enable, iw_write_addr, iw_write_data,
               iw_write_mode, iw_hw_we, iw_hw_addr, iw_hw_data, iw_instret,
        input  ow_read_data, ow_write_err
    );

    // CSR bank side.
    modport slave (
        input  iw_read_addr, iw_write_enable, iw_write_addr, iw_write_data,
               iw_write_mode, iw_hw_we, iw_hw_addr, iw_hw_data, iw_instret,
        output ow_read_data, ow_write_err
    );
endinterface

// File: rtl/csr_bank.sv
// CSR bank with set/clear RMW writes, a hardware-owned read-only region and cycle/instret counters.
// Latency: reads are combinational; writes land at the next iw_clk edge; write error one cycle later.
// Backpressure: none. Illegal writes are dropped and flagged, never stalled.
module csr_bank #(
    parameter int              DATA_W  = 24,
    parameter int              ADDR_W  = 8,
    parameter int              NUM_RD  = 2,
    parameter logic [ADDR_W-1:0] RO_BASE = 8'hC0,
    parameter logic [ADDR_W-1:0] CYC_LO  = 8'hF0,
    parameter logic [ADDR_W-1:0] INS_LO  = 8'hF2
) (
    input  logic         iw_clk,
    input  logic         iw_rst_n,
    csr_bank_if.slave    bus
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam int              CNT_W  = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] CYC_HI = CYC_LO + 1'b1;
    localparam logic [ADDR_W-1:0] INS_HI = INS_LO + 1'b1;

    typedef enum logic [1:0] {
        WM_WRITE = 2'b00,
        WM_SET   = 2'b01,
        WM_CLR   = 2'b10,
        WM_RSVD  = 2'b11
    } wr_mode_t;

    logic [DATA_W-1:0] csr_mem [DEPTH];
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  ins_cnt;
    logic [CNT_W-1:0]  cyc_nxt;
    logic [CNT_W-1:0]  ins_nxt;
    logic              write_err;

    logic [DATA_W-1:0] sw_old;
    logic [DATA_W-1:0] sw_new;
    logic              sw_is_ctr;
    logic              sw_legal;
    logic              sw_mem_we;
    logic              sw_err;
    logic              hw_legal;
    wr_mode_t          sw_mode;

    function automatic logic is_ctr(input logic [ADDR_W-1:0] a);
        return (a == CYC_LO) || (a == CYC_HI) || (a == INS_LO) || (a == INS_HI);
    endfunction

    // Counter words are synthesised from the counters; everything else comes from storage.
    function automatic logic [DATA_W-1:0] csr_value(input logic [ADDR_W-1:0] a);
        if (a == CYC_LO)      return cyc_cnt[DATA_W-1:0];
        else if (a == CYC_HI) return cyc_cnt[CNT_W-1:DATA_W];
        else if (a == INS_LO) return ins_cnt[DATA_W-1:0];
        else if (a == INS_HI) return ins_cnt[CNT_W-1:DATA_W];
        else                  return csr_mem[a];
    endfunction

    // Combinational read ports straight from current state (no write bypass).
    always_comb begin
        bus.ow_read_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.ow_read_data[k*DATA_W +: DATA_W] = csr_value(bus.iw_read_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    // Software write legality and read-modify-write result.
    always_comb begin
        sw_mode   = wr_mode_t'(bus.iw_write_mode);
        sw_old    = csr_value(bus.iw_write_addr);
        sw_is_ctr = is_ctr(bus.iw_write_addr);
        hw_legal  = bus.iw_hw_we && (bus.iw_hw_addr >= RO_BASE) && !is_ctr(bus.iw_hw_addr);
        sw_new    = sw_old;
        case (sw_mode)
            WM_WRITE: sw_new = bus.iw_write_data;
            WM_SET:   sw_new = sw_old | bus.iw_write_data;
            WM_CLR:   sw_new = sw_old & ~bus.iw_write_data;
            default:  sw_new = sw_old;
        endcase
        sw_legal  = bus.iw_write_enable && (sw_mode != WM_RSVD) &&
                    ((bus.iw_write_addr < RO_BASE) || sw_is_ctr);
        sw_mem_we = sw_legal && !sw_is_ctr;
        // A same-address hardware update absorbs the software write silently.
        sw_err    = bus.iw_write_enable && (sw_mode != WM_RSVD) &&
                    (bus.iw_write_addr >= RO_BASE) && !sw_is_ctr &&
                    !(hw_legal && (bus.iw_hw_addr == bus.iw_write_addr));
    end

    // Counter next state: a software load of either half replaces that cycle's increment.
    always_comb begin
        cyc_nxt = cyc_cnt + 1'b1;
        if (sw_legal && (bus.iw_write_addr == CYC_LO))
            cyc_nxt = {cyc_cnt[CNT_W-1:DATA_W], sw_new};
        else if (sw_legal && (bus.iw_write_addr == CYC_HI))
            cyc_nxt = {sw_new, cyc_cnt[DATA_W-1:0]};

        ins_nxt = bus.iw_instret ? (ins_cnt + 1'b1) : ins_cnt;
        if (sw_legal && (bus.iw_write_addr == INS_LO))
            ins_nxt = {ins_cnt[CNT_W-1:DATA_W], sw_new};
        else if (sw_legal && (bus.iw_write_addr == INS_HI))
            ins_nxt = {sw_new, ins_cnt[DATA_W-1:0]};
    end

    // Storage update; the hardware write is last so it wins on an address clash.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < DEPTH; i++) csr_mem[i] <= '0;
        end else begin
            if (sw_mem_we) csr_mem[bus.iw_write_addr] <= sw_new;
            if (hw_legal)  csr_mem[bus.iw_hw_addr]    <= bus.iw_hw_data;
        end
    end

    // Counters and the one-cycle write error pulse.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            cyc_cnt   <= '0;
            ins_cnt   <= '0;
            write_err <= 1'b0;
        end else begin
            cyc_cnt   <= cyc_nxt;
            ins_cnt   <= ins_nxt;
            write_err <= sw_err;
        end
    end

    assign bus.ow_write_err = write_err;

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: RMW modes, RO region, hw/sw collisions, counters, async reset.
// Latency: checks sampled 1 time unit after the active edge or mid-cycle for combinational reads.
// Backpressure: not applicable; the DUT never stalls.
module tb_csr_bank;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 8;
    localparam int NUM_RD = 2;

    logic iw_clk;
    logic iw_rst_n;
    int   n_checks;
    int   n_fail;

    csr_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    csr_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .RO_BASE(8'hC0),
        .CYC_LO (8'hF0),
        .INS_LO (8'hF2)
    ) u_dut (
        .iw_clk  (iw_clk),
        .iw_rst_n(iw_rst_n),
        .bus     (bus)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Combinational read through port 0 (port 1 mirrors the address).
    task automatic rd(input logic [7:0] a, output logic [23:0] d);
        bus.iw_read_addr = {a, a};
        #1;
        d = bus.ow_read_data[23:0];
    endtask

    task automatic sw_wr(input logic [7:0] a, input logic [23:0] d, input logic [1:0] m);
        @(negedge iw_clk);
        bus.iw_write_enable = 1'b1;
        bus.iw_write_addr   = a;
        bus.iw_write_data   = d;
        bus.iw_write_mode   = m;
        @(posedge iw_clk);
        #1;
        bus.iw_write_enable = 1'b0;
    endtask

    task automatic hw_wr(input logic [7:0] a, input logic [23:0] d);
        @(negedge iw_clk);
        bus.iw_hw_we   = 1'b1;
        bus.iw_hw_addr = a;
        bus.iw_hw_data = d;
        @(posedge iw_clk);
        #1;
        bus.iw_hw_we = 1'b0;
    endtask

    task automatic both_wr(input logic [7:0] sa, input logic [23:0] sd,
                           input logic [7:0] ha, input logic [23:0] hd);
        @(negedge iw_clk);
        bus.iw_write_enable = 1'b1;
        bus.iw_write_addr   = sa;
        bus.iw_write_data   = sd;
        bus.iw_write_mode   = 2'b00;
        bus.iw_hw_we        = 1'b1;
        bus.iw_hw_addr      = ha;
        bus.iw_hw_data      = hd;
        @(posedge iw_clk);
        #1;
        bus.iw_write_enable = 1'b0;
        bus.iw_hw_we        = 1'b0;
    endtask

    task automatic instret_pulse(input logic with_wr);
        @(negedge iw_clk);
        bus.iw_instret = 1'b1;
        if (with_wr) begin
            bus.iw_write_enable = 1'b1;
            bus.iw_write_addr   = 8'hF2;
            bus.iw_write_data   = 24'h000010;
            bus.iw_write_mode   = 2'b00;
        end
        @(posedge iw_clk);
        #1;
        bus.iw_instret      = 1'b0;
        bus.iw_write_enable = 1'b0;
    endtask

    initial begin
        logic [23:0] d;
        logic [23:0] d2;
        logic [23:0] acc;
        n_checks = 0;
        n_fail   = 0;
        iw_rst_n            = 1'b0;
        bus.iw_read_addr    = '0;
        bus.iw_write_enable = 1'b0;
        bus.iw_write_addr   = '0;
        bus.iw_write_data   = '0;
        bus.iw_write_mode   = 2'b00;
        bus.iw_hw_we        = 1'b0;
        bus.iw_hw_addr      = '0;
        bus.iw_hw_data      = '0;
        bus.iw_instret      = 1'b0;

        // Reset state: every address on both ports reads zero.
        #2;
        acc = '0;
        for (int a = 0; a < 256; a++) begin
            bus.iw_read_addr = {8'(a), 8'(a)};
            #1;
            acc = acc | bus.ow_read_data[23:0] | bus.ow_read_data[47:24];
        end
        check_eq("reset_all_zero", 48'(acc), 48'h0);
        check_eq("reset_err", 48'(bus.ow_write_err), 48'h0);

        // Cycle counter reads 3 after the third edge following reset release.
        @(negedge iw_clk);
        iw_rst_n = 1'b1;
        repeat (3) @(posedge iw_clk);
        #1;
        rd(8'hF0, d);
        check_eq("cycle_after_reset", 48'(d), 48'h3);

        // RMW modes on a plain register.
        sw_wr(8'h10, 24'h00F0F0, 2'b00);
        rd(8'h10, d);
        check_eq("mode_write", 48'(d), 48'h00F0F0);
        sw_wr(8'h10, 24'h0F0000, 2'b01);
        rd(8'h10, d);
        check_eq("mode_set", 48'(d), 48'h0FF0F0);
        sw_wr(8'h10, 24'h0000F0, 2'b10);
        rd(8'h10, d);
        check_eq("mode_clear", 48'(d), 48'h0FF000);
        sw_wr(8'h10, 24'hFFFFFF, 2'b11);
        check_eq("mode_rsvd_no_err", 48'(bus.ow_write_err), 48'h0);
        rd(8'h10, d);
        check_eq("mode_rsvd_no_write", 48'(d), 48'h0FF000);

        // Both read ports on the same location.
        bus.iw_read_addr = {8'h10, 8'h10};
        #1;
        check_eq("port0_same", 48'(bus.ow_read_data[23:0]), 48'h0FF000);
        check_eq("port1_same", 48'(bus.ow_read_data[47:24]), 48'h0FF000);

        // Software write into RO region: dropped, one-cycle error.
        sw_wr(8'hC5, 24'h123456, 2'b00);
        check_eq("ro_err_pulse", 48'(bus.ow_write_err), 48'h1);
        rd(8'hC5, d);
        check_eq("ro_unchanged", 48'(d), 48'h0);
        @(posedge iw_clk);
        #1;
        check_eq("ro_err_one_cycle", 48'(bus.ow_write_err), 48'h0);
        hw_wr(8'hC5, 24'hABCDEF);
        rd(8'hC5, d);
        check_eq("hw_write_ro", 48'(d), 48'hABCDEF);

        // Hardware write below RO_BASE is ignored.
        hw_wr(8'h30, 24'h555555);
        rd(8'h30, d);
        check_eq("hw_below_ro_ignored", 48'(d), 48'h0);

        // Collisions.
        both_wr(8'hC5, 24'h111111, 8'hC5, 24'h222222);
        check_eq("same_addr_no_err", 48'(bus.ow_write_err), 48'h0);
        rd(8'hC5, d);
        check_eq("same_addr_hw_wins", 48'(d), 48'h222222);
        both_wr(8'h20, 24'h333333, 8'hC6, 24'h444444);
        rd(8'h20, d);
        check_eq("diff_addr_sw", 48'(d), 48'h333333);
        rd(8'hC6, d);
        check_eq("diff_addr_hw", 48'(d), 48'h444444);

        // Cycle counter loads and carry.
        sw_wr(8'hF1, 24'h000000, 2'b00);
        sw_wr(8'hF0, 24'hFFFFFF, 2'b00);
        rd(8'hF0, d);
        rd(8'hF1, d2);
        check_eq("cyc_load_lo", 48'(d), 48'hFFFFFF);
        check_eq("cyc_load_hi", 48'(d2), 48'h000000);
        @(posedge iw_clk);
        #1;
        rd(8'hF0, d);
        rd(8'hF1, d2);
        check_eq("cyc_carry_lo", 48'(d), 48'h000000);
        check_eq("cyc_carry_hi", 48'(d2), 48'h000001);
        sw_wr(8'hF1, 24'hFFFFFF, 2'b00);
        sw_wr(8'hF0, 24'hFFFFFF, 2'b00);
        rd(8'hF0, d);
        rd(8'hF1, d2);
        check_eq("cyc_max", 48'({d2, d}), 48'hFFFFFF_FFFFFF);
        @(posedge iw_clk);
        #1;
        rd(8'hF0, d);
        rd(8'hF1, d2);
        check_eq("cyc_wrap", 48'({d2, d}), 48'h0);

        // Instret: 2 increments, load 0x10 (beats increment), 2 more increments.
        instret_pulse(1'b0);
        instret_pulse(1'b0);
        instret_pulse(1'b1);
        instret_pulse(1'b0);
        instret_pulse(1'b0);
        rd(8'hF2, d);
        check_eq("instret_lo", 48'(d), 48'h12);
        rd(8'hF3, d);
        check_eq("instret_hi", 48'(d), 48'h0);

        // Asynchronous reset between edges clears everything immediately.
        @(posedge iw_clk);
        #3;
        iw_rst_n = 1'b0;
        #1;
        acc = '0;
        rd(8'h10, d);  acc = acc | d;
        rd(8'hC5, d);  acc = acc | d;
        rd(8'hF0, d);  acc = acc | d;
        rd(8'hF2, d);  acc = acc | d;
        check_eq("async_reset_reads", 48'(acc), 48'h0);

        // A write presented during reset is lost.
        sw_wr(8'h10, 24'h777777, 2'b00);
        @(negedge iw_clk);
        iw_rst_n = 1'b1;
        #1;
        rd(8'h10, d);
        check_eq("write_in_reset_lost", 48'(d), 48'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
